coh_noc_vc_link_arbiter: RTL and testbench

Shares one physical NoC link among the four CHI virtual channels (REQ, RSP, DAT, SNP) using credit-based flow control. It sits between a node's per-VC output queues and the router input port. Each VC has a credit counter that mirrors free downstream buffer slots. A round-robin scheduler, with an optional strict-priority mode for RSP, grants at most one flit per cycle into a registered link stage.

---
 rtl/coh_noc_vc_link_arbiter.sv | 110 +++++++++++
 tb/tb_coh_noc_vc_link_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/coh_noc_vc_link_arbiter.sv
// Credit-based four-VC (REQ/RSP/DAT/SNP) link arbiter with a registered link stage.
// Optional feature: define COH_NOC_VC_ARB_RSP_PRIO_EN to give RSP strict priority.
module coh_noc_vc_link_arbiter #(
  parameter int FLIT_W       = 512,
  parameter int INIT_CREDITS = 16,
  parameter int MAX_CRED     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [4*FLIT_W-1:0]   in_flit,
  output logic [3:0]            in_ready,
  input  logic [3:0]            credit_ret,
  output logic                  out_valid,
  output logic [FLIT_W-1:0]     out_flit,
  output logic [1:0]            out_vc,
  output logic [4*8-1:0]        credit_cnt,
  output logic [3:0]            err_credit_ovf
);

  localparam logic [7:0] INIT_C = 8'(INIT_CREDITS);
  localparam logic [7:0] MAX_C  = 8'(MAX_CRED);

  logic [7:0]        cnt_reg   [4];
  logic              err_reg   [4];
  logic [FLIT_W-1:0] flit_arr  [4];
  logic [3:0]        elig;
  logic [3:0]        grant;
  logic              grant_any;
  logic [1:0]        grant_idx;
  logic [1:0]        scan_idx;
  logic              ptr_upd;
  logic [1:0]        rr_ptr_reg;
  logic              out_valid_reg;
  logic [FLIT_W-1:0] out_flit_reg;
  logic [1:0]        out_vc_reg;

  // Nothing is eligible while in reset, which keeps in_ready low then.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_vc
      assign flit_arr[gi]              = in_flit[gi*FLIT_W +: FLIT_W];
      assign elig[gi]                  = in_valid[gi] && (cnt_reg[gi] != 8'd0) && !rst;
      assign credit_cnt[gi*8 +: 8]     = cnt_reg[gi];
      assign err_credit_ovf[gi]        = err_reg[gi];

      // Simultaneous grant and return cancel out, so no overflow is possible then.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= INIT_C;
          err_reg[gi] <= 1'b0;
        end else begin
          case ({grant[gi], credit_ret[gi]})
            2'b10:   cnt_reg[gi] <= cnt_reg[gi] - 8'd1;
            2'b01: begin
              if (cnt_reg[gi] == MAX_C) err_reg[gi] <= 1'b1;
              else                      cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
            end
            default: cnt_reg[gi] <= cnt_reg[gi];
          endcase
        end
      end
    end
  endgenerate

  always_comb begin
    grant_any = 1'b0;
    grant_idx = rr_ptr_reg;
    scan_idx  = rr_ptr_reg;
    for (int i = 0; i < 4; i++) begin
      scan_idx = rr_ptr_reg + 2'(i);
      if (!grant_any && elig[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    ptr_upd = grant_any;
`ifdef COH_NOC_VC_ARB_RSP_PRIO_EN
    // RSP overrides the rotation and leaves the pointer where it was.
    if (elig[1]) begin
      grant_any = 1'b1;
      grant_idx = 2'd1;
      ptr_upd   = 1'b0;
    end
`endif
  end

  assign grant    = grant_any ? (4'b0001 << grant_idx) : 4'b0000;
  assign in_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_reg    <= 2'd0;
      out_valid_reg <= 1'b0;
      out_flit_reg  <= '0;
      out_vc_reg    <= 2'd0;
    end else begin
      out_valid_reg <= grant_any;
      if (ptr_upd) rr_ptr_reg <= grant_idx + 2'd1;
      if (grant_any) begin
        out_flit_reg <= flit_arr[grant_idx];
        out_vc_reg   <= grant_idx;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_flit  = out_flit_reg;
  assign out_vc    = out_vc_reg;

endmodule

// File: tb/tb_coh_noc_vc_link_arbiter.sv
// Scoreboard bench for coh_noc_vc_link_arbiter: directed scenarios plus random traffic
// against a credit/round-robin reference model.
module tb_coh_noc_vc_link_arbiter;
  localparam int FLIT_W = 64;
  localparam int INIT   = 16;
  localparam int MAXC   = 16;
`ifdef COH_NOC_VC_ARB_RSP_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          in_valid;
  logic [4*FLIT_W-1:0] in_flit;
  logic [3:0]          in_ready;
  logic [3:0]          credit_ret;
  logic                out_valid;
  logic [FLIT_W-1:0]   out_flit;
  logic [1:0]          out_vc;
  logic [31:0]         credit_cnt;
  logic [3:0]          err_credit_ovf;

  coh_noc_vc_link_arbiter #(.FLIT_W(FLIT_W), .INIT_CREDITS(INIT), .MAX_CRED(MAXC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .credit_ret(credit_ret), .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc),
    .credit_cnt(credit_cnt), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_cred [4];
  int m_ptr;
  bit m_err  [4];
  logic [FLIT_W+1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // First eligible VC in rotation order from the pointer; RSP first in priority mode.
  task automatic model_pick(input logic [3:0] v, input logic rs, output bit found, output int g);
    found = 0;
    g = 0;
    if (rs) return;
    if (PRIO && v[1] && m_cred[1] > 0) begin
      found = 1;
      g = 1;
      return;
    end
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (m_ptr + k) % 4;
      if (!found && v[c] && m_cred[c] > 0) begin
        found = 1;
        g = c;
      end
    end
  endtask

  task automatic step(input logic [3:0] v, input logic [3:0] r, input logic rs);
    bit   found;
    int   g;
    logic [3:0] exp_ready;
    in_valid   = v;
    credit_ret = r;
    rst        = rs;
    for (int i = 0; i < 4; i++) in_flit[i*FLIT_W +: FLIT_W] = {$urandom, $urandom};
    #1;
    model_pick(v, rs, found, g);
    exp_ready = found ? (4'b0001 << g) : 4'b0000;
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    if (found) exp_q.push_back({2'(g), in_flit[g*FLIT_W +: FLIT_W]});
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        m_cred[i] = INIT;
        m_err[i]  = 0;
      end
      m_ptr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit gr;
        gr = found && (g == i);
        if (gr && !r[i])      m_cred[i] = m_cred[i] - 1;
        else if (!gr && r[i]) begin
          if (m_cred[i] == MAXC) m_err[i] = 1;
          else                   m_cred[i] = m_cred[i] + 1;
        end
      end
      if (found && !(PRIO && g == 1)) m_ptr = (g + 1) % 4;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("credit_cnt[%0d]", i), 64'(credit_cnt[i*8 +: 8]), 64'(m_cred[i]));
      chk($sformatf("err_credit_ovf[%0d]", i), 64'(err_credit_ovf[i]), 64'(m_err[i]));
    end
    if (rs) begin
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset out_vc", 64'(out_vc), 64'd0);
      chk("reset out_flit", 64'(out_flit), 64'd0);
    end
    $display("cyc valid=%b ret=%b rst=%b ready=%b cred=%h err=%b", v, r, rs, in_ready,
             credit_cnt, err_credit_ovf);
  endtask

  // Monitor: every link flit must match the oldest outstanding grant.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL link_unexpected actual=vc%0d expected=no flit", out_vc);
        end else begin
          logic [FLIT_W+1:0] e;
          e = exp_q.pop_front();
          chk("link_vc", 64'(out_vc), 64'(e[FLIT_W +: 2]));
          chk("link_flit", 64'(out_flit), 64'(e[FLIT_W-1:0]));
        end
      end
    end
  end

  initial begin
    in_valid = 4'b0;
    credit_ret = 4'b0;
    in_flit = '0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_cred[i] = INIT;
      m_err[i]  = 0;
    end
    m_ptr = 0;

    // Reset, then full drain of all four VCs
    repeat (2) step(4'b0000, 4'b0000, 1'b1);
    repeat (70) step(4'b1111, 4'b0000, 1'b0);

    // Single REQ credit return re-enables REQ the next cycle
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);

    // DAT at 5 credits: grant and return in the same cycle
    step(4'b0000, 4'b0000, 1'b1);
    repeat (11) step(4'b0100, 4'b0000, 1'b0);
    step(4'b0100, 4'b0100, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Overflow at MAX_CRED is sticky; all four returning at once
    step(4'b0000, 4'b0000, 1'b1);
    step(4'b0000, 4'b1001, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b0000, 4'b1111, 1'b0);

    // Reset mid-operation
    repeat (7) step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b1);
    repeat (3) step(4'b1111, 4'b0000, 1'b0);

    // Random traffic with occasional resets
    repeat (600) begin
      logic [3:0] rv, rr;
      rv = 4'($urandom);
      rr = 4'($urandom) & 4'($urandom);
      step(rv, rr, ($urandom_range(0, 99) == 0));
    end

    repeat (3) step(4'b0000, 4'b0000, 1'b0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
